// File: rtl/vending_pkg.sv
// -----------------------------------------------------------------------------
// vending_pkg
// Shared definitions for the vending controller: the credit state encoding,
// the coin-acceptor codes and the product price.
// Optional feature macro used by this slice: VEND_REFUND_EN (cancel/refund).
// -----------------------------------------------------------------------------
package vending_pkg;

    // Credit held between sales; 2'b11 is unused and recovers to S0.
    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10
    } state_t;

    // Coin codes presented by the acceptor front end, one per clock.
    localparam logic [1:0] COIN_NONE   = 2'b00;
    localparam logic [1:0] COIN_ONE    = 2'b01;
    localparam logic [1:0] COIN_TWO    = 2'b10;
    localparam logic [1:0] COIN_CANCEL = 2'b11;

    // Price of one product in units, sized for the 3-bit credit sum.
    localparam logic [2:0] PRICE = 3'd3;

endpackage

// File: rtl/vending_coin_decode.sv
// -----------------------------------------------------------------------------
// vending_coin_decode
// Maps the raw coin code to a coin value in units and a cancel flag.
//   in     : coin code (00 none, 01 one, 10 two, 11 cancel/reserved)
//   coin   : coin value 0..2
//   cancel : refund request (only when VEND_REFUND_EN is defined)
// With VEND_REFUND_EN undefined, code 11 decodes exactly like 00.
// -----------------------------------------------------------------------------
module vending_coin_decode
    import vending_pkg::*;
(
    input  logic [1:0] in,
    output logic [1:0] coin,
    output logic       cancel
);

    always_comb begin
        coin   = 2'd0;
        cancel = 1'b0;
        case (in)
            COIN_ONE:    coin = 2'd1;
            COIN_TWO:    coin = 2'd2;
`ifdef VEND_REFUND_EN
            COIN_CANCEL: cancel = 1'b1;
`else
            COIN_CANCEL: cancel = 1'b0;
`endif
            default:     coin = 2'd0;
        endcase
    end

endmodule

// File: rtl/vending_machine.sv
// -----------------------------------------------------------------------------
// vending_machine
// Credit-accumulating vending controller, price 3 units. Dispenses one
// product when credit reaches the price and returns the excess as change.
//   clk    : system clock, rising edge
//   rst    : asynchronous active-low reset
//   in     : coin code sampled every rising edge
//   out    : one-cycle dispense pulse (registered)
//   change : change amount in units, valid with its pulse (registered)
// Optional feature: VEND_REFUND_EN makes in = 11 a cancel that refunds the
// current credit as change.
// -----------------------------------------------------------------------------
module vending_machine
    import vending_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] in,
    output logic       out,
    output logic [1:0] change
);

    logic [1:0] coin;
    logic       cancel;

    state_t     state_reg, state_next;
    logic       out_reg, out_next;
    logic [1:0] change_reg, change_next;
    logic [2:0] total;

    vending_coin_decode u_decode (
        .in     (in),
        .coin   (coin),
        .cancel (cancel)
    );

    // State and output registers share one edge so outputs line up with
    // the transition that produced them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= S0;
            out_reg    <= 1'b0;
            change_reg <= 2'b00;
        end else begin
            state_reg  <= state_next;
            out_reg    <= out_next;
            change_reg <= change_next;
        end
    end

    always_comb begin
        state_next  = S0;
        out_next    = 1'b0;
        change_next = 2'b00;
        // Credit never exceeds 2 and a coin never exceeds 2, so total <= 4.
        total       = {1'b0, state_reg} + {1'b0, coin};
        case (state_reg)
            S0, S1, S2: begin
                if (cancel) begin
                    // Refund: whatever credit is held goes back as change.
                    change_next = state_reg;
                end else if (total >= PRICE) begin
                    out_next    = 1'b1;
                    change_next = 2'(total - PRICE);
                end else begin
                    state_next  = state_t'(total[1:0]);
                end
            end
            // Illegal encoding: fall back to S0 silently.
            default: state_next = S0;
        endcase
    end

    assign out    = out_reg;
    assign change = change_reg;

endmodule

// File: tb/tb_vending_machine.sv
// -----------------------------------------------------------------------------
// tb_vending_machine
// Directed testbench for vending_machine: reset behaviour, exact, over- and
// mixed payment, idle hold, mid-operation reset and the cancel code.
// -----------------------------------------------------------------------------
module tb_vending_machine;

    logic       clk;
    logic       rst;
    logic [1:0] in;
    logic       out;
    logic [1:0] change;

    int compared   = 0;
    int mismatched = 0;

    vending_machine dut (
        .clk    (clk),
        .rst    (rst),
        .in     (in),
        .out    (out),
        .change (change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] exp_state,
                         input logic exp_out, input logic [1:0] exp_change);
        logic [1:0] st;
        st = dut.state_reg;
        compared++;
        assert (st === exp_state) else begin
            mismatched++;
            $error("FAIL %s state: got %b expected %b", tag, st, exp_state);
        end
        compared++;
        assert (out === exp_out) else begin
            mismatched++;
            $error("FAIL %s out: got %b expected %b", tag, out, exp_out);
        end
        compared++;
        assert (change === exp_change) else begin
            mismatched++;
            $error("FAIL %s change: got %b expected %b", tag, change, exp_change);
        end
        $display("%s: in=%b state=%b out=%b change=%b", tag, in, st, out, change);
    endtask

    // Drive a coin at the falling edge, then observe 1 time unit after the
    // next rising edge.
    task automatic step(input logic [1:0] coin, input string tag,
                        input logic [1:0] exp_state, input logic exp_out,
                        input logic [1:0] exp_change);
        @(negedge clk);
        in = coin;
        @(posedge clk);
        #1;
        check(tag, exp_state, exp_out, exp_change);
    endtask

    initial begin
        rst = 1'b0;
        in  = 2'b01;

        // Reset held low with coins present: nothing is counted.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("reset_hold%0d", i), 2'b00, 1'b0, 2'b00);
        end

        // Release reset together with a one-unit coin: first counted coin.
        @(negedge clk);
        rst = 1'b1;
        in  = 2'b01;
        @(posedge clk);
        #1;
        check("release_first_coin", 2'b01, 1'b0, 2'b00);

        // Exact payment continues: S1 -> S2 -> sale.
        step(2'b01, "exact_s2",   2'b10, 1'b0, 2'b00);
        step(2'b01, "exact_sale", 2'b00, 1'b1, 2'b00);
        step(2'b00, "exact_idle", 2'b00, 1'b0, 2'b00);

        // Overpayment: 2 + 2 = 4 -> sale with one unit change.
        step(2'b10, "over_s2",   2'b10, 1'b0, 2'b00);
        step(2'b10, "over_sale", 2'b00, 1'b1, 2'b01);
        step(2'b00, "over_idle", 2'b00, 1'b0, 2'b00);

        // Mixed payment: 1 + 2 = 3 -> sale, no change, then idle.
        step(2'b01, "mixed_s1",   2'b01, 1'b0, 2'b00);
        step(2'b10, "mixed_sale", 2'b00, 1'b1, 2'b00);
        for (int i = 0; i < 3; i++)
            step(2'b00, $sformatf("mixed_idle%0d", i), 2'b00, 1'b0, 2'b00);

        // S2 + one unit -> sale, no change.
        step(2'b10, "s2one_s2",   2'b10, 1'b0, 2'b00);
        step(2'b01, "s2one_sale", 2'b00, 1'b1, 2'b00);

        // Idle hold at S2, then asynchronous reset mid-operation.
        step(2'b10, "hold_s2", 2'b10, 1'b0, 2'b00);
        for (int i = 0; i < 5; i++)
            step(2'b00, $sformatf("hold_idle%0d", i), 2'b10, 1'b0, 2'b00);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset", 2'b00, 1'b0, 2'b00);
        @(negedge clk);
        rst = 1'b1;
        step(2'b01, "after_reset_s1", 2'b01, 1'b0, 2'b00);

        // Cancel from S2 (S1 + 1 = S2), then from S1.
        step(2'b01, "cancel_s2", 2'b10, 1'b0, 2'b00);
`ifdef VEND_REFUND_EN
        step(2'b11, "cancel_refund2", 2'b00, 1'b0, 2'b10);
        step(2'b01, "cancel_s1",      2'b01, 1'b0, 2'b00);
        step(2'b11, "cancel_refund1", 2'b00, 1'b0, 2'b01);
        step(2'b11, "cancel_refund0", 2'b00, 1'b0, 2'b00);
`else
        step(2'b11, "cancel_ignored2", 2'b10, 1'b0, 2'b00);
        step(2'b01, "cancel_sale",     2'b00, 1'b1, 2'b00);
        step(2'b11, "cancel_ignored0", 2'b00, 1'b0, 2'b00);
`endif
        step(2'b00, "final_idle", 2'b00, 1'b0, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Safety bound so the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
